fpu_writeback_arbiter: RTL

- Write-back stage directly upstream of the FPU register file. It merges two result sources onto the single synchronous write port (WriteData/WriteRegister/RegWrite):
  - the multi-cycle FPU datapath, which has backpressure;
  - the load/move path (LWC1/MTC1), which cannot stall.
- FPU results are buffered in a small FIFO.
- A 32-bit pending scoreboard tracks FPU registers with in-flight writes, for the issue stage's RAW/WAW stall logic.

---
 rtl/fpu_writeback_arbiter_pkg.sv | 13 +
 rtl/fpu_wb_fifo.sv | 71 +++++++
 rtl/fpu_writeback_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/fpu_writeback_arbiter_pkg.sv
// Shared widths and the write-bundle type for the FPU write-back stage.
package fpu_writeback_arbiter_pkg;

  localparam int FPU_REG_ADDR_W = 5;
  localparam int FPU_DATA_W     = 32;
  localparam int FPU_NUM_REGS   = 32;

  typedef struct packed {
    logic [FPU_REG_ADDR_W-1:0] dest;
    logic [FPU_DATA_W-1:0]     data;
  } wb_bundle_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// In-order result buffer between the FPU datapath and the register-file write port.
module fpu_wb_fifo
  import fpu_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_bundle_t       din,
  output wb_bundle_t       dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_bundle_t             mem_q [DEPTH];
  wb_bundle_t             mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fpu_writeback_arbiter.sv
// Merges buffered FPU results and non-stallable load/move results onto the
// FPU register-file write port, and tracks registers with writes in flight.
module fpu_writeback_arbiter
  import fpu_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      IssueValid,
  input  logic [FPU_REG_ADDR_W-1:0] IssueDest,
  input  logic                      FpuValid,
  output logic                      FpuReady,
  input  logic [FPU_REG_ADDR_W-1:0] FpuDest,
  input  logic [FPU_DATA_W-1:0]     FpuData,
  input  logic                      MemValid,
  input  logic [FPU_REG_ADDR_W-1:0] MemDest,
  input  logic [FPU_DATA_W-1:0]     MemData,
  output logic [FPU_DATA_W-1:0]     WriteData,
  output logic [FPU_REG_ADDR_W-1:0] WriteRegister,
  output logic                      RegWrite,
  output logic [FPU_NUM_REGS-1:0]   Pending,
  output logic [CNT_W-1:0]          FifoCount
);

  wb_bundle_t                fifo_din, fifo_dout;
  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FPU_DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [FPU_REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic                      reg_write_q, reg_write_d;
  logic [FPU_NUM_REGS-1:0]   pending_q, pending_d;

  assign FpuReady  = Reset_n && !fifo_full;
  assign fifo_push = FpuValid && FpuReady;
  // Load/move results cannot stall, so they always pre-empt the FIFO head.
  assign fifo_pop  = !MemValid && !fifo_empty;
  assign fifo_din  = '{dest: FpuDest, data: FpuData};

  fpu_wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (FifoCount),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    wr_data_d   = wr_data_q;
    wr_reg_d    = wr_reg_q;
    reg_write_d = 1'b0;
    if (MemValid) begin
      wr_data_d   = MemData;
      wr_reg_d    = MemDest;
      reg_write_d = 1'b1;
    end else if (!fifo_empty) begin
      wr_data_d   = fifo_dout.data;
      wr_reg_d    = fifo_dout.dest;
      reg_write_d = 1'b1;
    end

    // Clear first so a same-edge issue to the committing register stays pending.
    pending_d = pending_q;
    if (reg_write_d) pending_d[wr_reg_d] = 1'b0;
    if (IssueValid)  pending_d[IssueDest] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_data_q   <= '0;
      wr_reg_q    <= '0;
      reg_write_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      wr_data_q   <= wr_data_d;
      wr_reg_q    <= wr_reg_d;
      reg_write_q <= reg_write_d;
      pending_q   <= pending_d;
    end
  end

  assign WriteData     = wr_data_q;
  assign WriteRegister = wr_reg_q;
  assign RegWrite      = reg_write_q;
  assign Pending       = pending_q;

endmodule
